// File: rtl/eth_rx_fcs_check.sv
// Ethernet RX FCS checker: CRC-32 check, 4-byte FCS strip, per-frame status.
// Optional saturating good/bad frame counters under `define FCS_STATS_EN.

module crc_engine (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init,
   input  logic        en,
   input  logic [7:0]  byte_in,
   output logic [31:0] crc
);

   logic [31:0] crc_q, crc_d;

   // Reflected CRC-32 (poly EDB88320), no final inversion in the register.
   always_comb begin
      crc_d = crc_q;
      if (init) begin
         crc_d = 32'hFFFF_FFFF;
      end else if (en) begin
         crc_d = crc_q ^ {24'h0, byte_in};
         for (int b = 0; b < 8; b++) begin
            if (crc_d[0]) crc_d = (crc_d >> 1) ^ 32'hEDB8_8320;
            else          crc_d = crc_d >> 1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) crc_q <= 32'hFFFF_FFFF;
      else        crc_q <= crc_d;
   end

   assign crc = crc_q;

endmodule

module eth_rx_fcs_check #(
   parameter int unsigned    MIN_FRAME   = 64,
   parameter int unsigned    MAX_FRAME   = 1518,
   parameter logic [31:0]    CRC_RESIDUE = 32'hDEBB20E3
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        s_valid,
   input  logic [7:0]  s_data,
   input  logic        s_last,
   input  logic        s_error,
   output logic        m_valid,
   output logic [7:0]  m_data,
   output logic        m_last,
   output logic        m_user,
   output logic        frame_done,
   output logic [2:0]  frame_status,
   output logic [31:0] frames_ok,
   output logic [31:0] frames_bad
);

   typedef enum logic [1:0] {IDLE, RECV, CHECK} state_e;

   state_e          state_q, state_d;
   logic            accept, in_check, crc_init;
   logic [31:0]     crc;
   logic [15:0]     cnt_q, cnt_d;
   logic            rxerr_q, rxerr_d;
   logic [3:0][7:0] dl_q, dl_d;
   logic [2:0]      fill_q, fill_d;
   logic            s1_valid_q, s1_valid_d;
   logic [7:0]      s1_data_q, s1_data_d;
   logic            s1_last_q, s1_last_d;
   logic            m_valid_q, m_last_q, m_user_q;
   logic [7:0]      m_data_q;
   logic            done_q;
   logic [2:0]      status_q, status_c;
   logic            len_err, fcs_err;
   logic [31:0]     n_bytes;

   crc_engine u_crc (
      .clk     (clk),
      .rst_n   (rst_n),
      .init    (crc_init),
      .en      (accept),
      .byte_in (s_data),
      .crc     (crc)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (s_valid) state_d = s_last ? CHECK : RECV;
         RECV:    if (s_valid && s_last) state_d = CHECK;
         CHECK:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept   = 1'b0;
      in_check = 1'b0;
      crc_init = 1'b0;
      unique case (state_q)
         IDLE, RECV: accept = s_valid;
         CHECK: begin
            in_check = 1'b1;
            crc_init = 1'b1;
         end
         default: ;
      endcase
   end

   // A frame shorter than the FCS carries no checksum to test; it is flagged as runt only.
   assign n_bytes  = {16'h0, cnt_q};
   assign len_err  = (n_bytes < MIN_FRAME) || (n_bytes > MAX_FRAME);
   assign fcs_err  = (n_bytes >= 32'd4) && (crc != CRC_RESIDUE);
   assign status_c = {len_err, rxerr_q, fcs_err};

   always_comb begin
      cnt_d      = cnt_q;
      rxerr_d    = rxerr_q;
      dl_d       = dl_q;
      fill_d     = fill_q;
      s1_valid_d = 1'b0;
      s1_data_d  = s1_data_q;
      s1_last_d  = s1_last_q;
      if (in_check) begin
         cnt_d   = '0;
         rxerr_d = 1'b0;
         fill_d  = '0;
      end else if (accept) begin
         if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
         rxerr_d = rxerr_q | s_error;
         dl_d    = {dl_q[2:0], s_data};
         if (fill_q == 3'd4) begin
            s1_valid_d = 1'b1;
            s1_data_d  = dl_q[3];
            s1_last_d  = s_last;
         end else begin
            fill_d = fill_q + 3'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q      <= '0;
         rxerr_q    <= 1'b0;
         dl_q       <= '0;
         fill_q     <= '0;
         s1_valid_q <= 1'b0;
         s1_data_q  <= '0;
         s1_last_q  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         rxerr_q    <= rxerr_d;
         dl_q       <= dl_d;
         fill_q     <= fill_d;
         s1_valid_q <= s1_valid_d;
         s1_data_q  <= s1_data_d;
         s1_last_q  <= s1_last_d;
      end
   end

   // The last payload byte sits in S1 during CHECK, so status and m_last leave together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         m_user_q  <= 1'b0;
         done_q    <= 1'b0;
         status_q  <= '0;
      end else begin
         m_valid_q <= s1_valid_q;
         if (s1_valid_q) m_data_q <= s1_data_q;
         m_last_q  <= s1_valid_q & s1_last_q;
         m_user_q  <= s1_valid_q & s1_last_q & (|status_c);
         done_q    <= in_check;
         status_q  <= in_check ? status_c : 3'b000;
      end
   end

   assign m_valid      = m_valid_q;
   assign m_data       = m_data_q;
   assign m_last       = m_last_q;
   assign m_user       = m_user_q;
   assign frame_done   = done_q;
   assign frame_status = status_q;

`ifdef FCS_STATS_EN
   logic [31:0] ok_q, bad_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ok_q  <= '0;
         bad_q <= '0;
      end else if (in_check) begin
         if (status_c == 3'b000) begin
            if (ok_q != 32'hFFFF_FFFF) ok_q <= ok_q + 32'd1;
         end else begin
            if (bad_q != 32'hFFFF_FFFF) bad_q <= bad_q + 32'd1;
         end
      end
   end

   assign frames_ok  = ok_q;
   assign frames_bad = bad_q;
`else
   assign frames_ok  = '0;
   assign frames_bad = '0;
`endif

   // Input must idle in the CHECK cycle; a byte arriving there is dropped.
   a_ifg : assert property (@(posedge clk) disable iff (!rst_n)
      !(state_q == CHECK && s_valid));

endmodule

// File: tb/tb_eth_rx_fcs_check.sv
// Bench for eth_rx_fcs_check: vector table of frames, scoreboarded payload and status.
// Stats counters are checked when FCS_STATS_EN is defined, else must read zero.

module tb_eth_rx_fcs_check;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_last, s_error;
   logic [7:0]  s_data;
   logic        m_valid, m_last, m_user, frame_done;
   logic [7:0]  m_data;
   logic [2:0]  frame_status;
   logic [31:0] frames_ok, frames_bad;

   eth_rx_fcs_check dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_last       (s_last),
      .s_error      (s_error),
      .m_valid      (m_valid),
      .m_data       (m_data),
      .m_last       (m_last),
      .m_user       (m_user),
      .frame_done   (frame_done),
      .frame_status (frame_status),
      .frames_ok    (frames_ok),
      .frames_bad   (frames_bad)
   );

   always #5 clk = ~clk;

   typedef struct {
      int       len;
      int       flip;
      int       err_at;
      bit       ascii;
      bit       gaps;
      logic [2:0] exp;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       last;
      logic       user;
   } beat_t;

   vec_t       vecs[8];
   beat_t      exq[$];
   logic [2:0] sq[$];
   logic [7:0] fr[$];
   int         nchk = 0;
   int         nfail = 0;
   int         exp_ok = 0;
   int         exp_bad = 0;
   int         abort_bad = 0;
   bit         abort_mode = 0;

   function automatic logic [31:0] crc_upd(logic [31:0] c, logic [7:0] b);
      logic [31:0] r;
      r = c;
      for (int k = 0; k < 8; k++) begin
         if (r[0] ^ b[k]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic build(input vec_t v);
      logic [31:0] c;
      logic [7:0]  s[9];
      s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
      fr.delete();
      if (v.len < 4) begin
         for (int i = 0; i < v.len; i++) fr.push_back(8'(8'hA0 + i));
      end else begin
         for (int i = 0; i < v.len - 4; i++)
            fr.push_back(v.ascii ? s[i] : 8'((i * 7 + 3) & 255));
         c = 32'hFFFFFFFF;
         foreach (fr[i]) c = crc_upd(c, fr[i]);
         c = ~c;
         for (int i = 0; i < 4; i++) fr.push_back(c[8*i +: 8]);
      end
      if (v.flip >= 0) fr[v.flip] = fr[v.flip] ^ 8'h01;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         s_valid = 1'b0;
         s_last  = 1'b0;
         s_error = 1'b0;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int err_at, input bit gaps);
      for (int i = 0; i < fr.size(); i++) begin
         if (gaps && (i % 7 == 3)) idle(1);
         s_valid = 1'b1;
         s_data  = fr[i];
         s_last  = (i == fr.size() - 1);
         s_error = (i == err_at);
         @(posedge clk);
         #1;
      end
      idle(1);
   endtask

   task automatic expect_frame(input logic [2:0] st);
      beat_t b;
      for (int i = 0; i < int'(fr.size()) - 4; i++) begin
         b.data = fr[i];
         b.last = (i == fr.size() - 5);
         b.user = b.last & (|st);
         exq.push_back(b);
      end
      sq.push_back(st);
      if (st == 3'b000) exp_ok++;
      else              exp_bad++;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exq.size() != 0 || sq.size() != 0) && n < 40) begin
         idle(1);
         n++;
      end
      nchk++;
      if (exq.size() != 0 || sq.size() != 0) begin
         nfail++;
         $display("FAIL drain: pending beats=%0d status=%0d, required 0/0",
                  exq.size(), sq.size());
         exq.delete();
         sq.delete();
      end
   endtask

   task automatic check_idle_outputs(input string name);
      nchk++;
      if ({m_valid, m_data, m_last, m_user, frame_done, frame_status,
           frames_ok, frames_bad} !== '0) begin
         nfail++;
         $display("FAIL %s: v=%b d=%h l=%b u=%b done=%b st=%b ok=%0d bad=%0d, required all 0",
                  name, m_valid, m_data, m_last, m_user, frame_done,
                  frame_status, frames_ok, frames_bad);
      end
   endtask

   task automatic check_stats(input string name);
      int req_ok, req_bad;
`ifdef FCS_STATS_EN
      req_ok  = exp_ok;
      req_bad = exp_bad;
`else
      req_ok  = 0;
      req_bad = 0;
`endif
      nchk++;
      if (frames_ok !== 32'(req_ok) || frames_bad !== 32'(req_bad)) begin
         nfail++;
         $display("FAIL %s: ok=%0d bad=%0d, required ok=%0d bad=%0d",
                  name, frames_ok, frames_bad, req_ok, req_bad);
      end
   endtask

   task automatic monitor();
      beat_t      e;
      logic [2:0] st;
      forever begin
         @(negedge clk);
         if (!rst_n) continue;
         if (abort_mode) begin
            if (frame_done || (m_valid && m_last)) abort_bad++;
            continue;
         end
         if (m_valid) begin
            nchk++;
            if (exq.size() == 0) begin
               nfail++;
               $display("FAIL beat_unexpected: d=%h l=%b, required no beat", m_data, m_last);
            end else begin
               e = exq.pop_front();
               if ({m_data, m_last, m_user} !== {e.data, e.last, e.user}) begin
                  nfail++;
                  $display("FAIL beat: d=%h l=%b u=%b, required d=%h l=%b u=%b",
                           m_data, m_last, m_user, e.data, e.last, e.user);
               end
            end
            if (m_last) begin
               nchk++;
               if (frame_done !== 1'b1) begin
                  nfail++;
                  $display("FAIL last_vs_done: done=%b, required 1", frame_done);
               end
            end
         end
         if (frame_done) begin
            nchk++;
            if (sq.size() == 0) begin
               nfail++;
               $display("FAIL done_unexpected: st=%b, required no frame_done", frame_status);
            end else begin
               st = sq.pop_front();
               if (frame_status !== st) begin
                  nfail++;
                  $display("FAIL status: st=%b, required %b", frame_status, st);
               end
            end
         end
      end
   endtask

   initial begin
      vecs[0] = '{len: 64,   flip: -1, err_at: -1, ascii: 0, gaps: 0, exp: 3'b000};
      vecs[1] = '{len: 64,   flip: 10, err_at: -1, ascii: 0, gaps: 1, exp: 3'b001};
      vecs[2] = '{len: 13,   flip: -1, err_at: -1, ascii: 1, gaps: 0, exp: 3'b100};
      vecs[3] = '{len: 1519, flip: -1, err_at: -1, ascii: 0, gaps: 0, exp: 3'b100};
      vecs[4] = '{len: 1518, flip: -1, err_at: -1, ascii: 0, gaps: 0, exp: 3'b000};
      vecs[5] = '{len: 3,    flip: -1, err_at: -1, ascii: 0, gaps: 0, exp: 3'b100};
      vecs[6] = '{len: 4,    flip: -1, err_at: -1, ascii: 0, gaps: 0, exp: 3'b100};
      vecs[7] = '{len: 64,   flip: -1, err_at: 20, ascii: 0, gaps: 1, exp: 3'b010};

      rst_n   = 1'b0;
      s_valid = 1'b0;
      s_data  = '0;
      s_last  = 1'b0;
      s_error = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset_state");
      rst_n = 1'b1;
      fork
         monitor();
      join_none
      idle(2);
      check_idle_outputs("idle_after_reset");

      for (int v = 0; v < 8; v++) begin
         build(vecs[v]);
         expect_frame(vecs[v].exp);
         send(vecs[v].err_at, vecs[v].gaps);
         idle(2);
         drain();
      end
      check_stats("stats_after_table");

      // Abort a frame with reset after 30 bytes
      build(vecs[0]);
      abort_mode = 1'b1;
      for (int i = 0; i < 30; i++) begin
         s_valid = 1'b1;
         s_data  = fr[i];
         s_last  = 1'b0;
         s_error = 1'b0;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      rst_n   = 1'b0;
      exp_ok  = 0;
      exp_bad = 0;
      repeat (2) @(posedge clk);
      #1;
      check_idle_outputs("mid_frame_reset");
      rst_n = 1'b1;
      idle(3);
      abort_mode = 1'b0;
      exq.delete();
      sq.delete();
      nchk++;
      if (abort_bad != 0) begin
         nfail++;
         $display("FAIL abort_outputs: last/done events=%0d, required 0", abort_bad);
      end

      build(vecs[0]);
      expect_frame(3'b000);
      send(-1, 1'b0);
      idle(2);
      drain();
      check_stats("stats_after_reset");

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
